// File: rtl/operand_entry.sv
// Button-driven signed decimal operand entry: debounced edit of a BCD buffer, then a serial
// Horner conversion to two's complement offered on a valid/ready port.
// Optional auto-repeat of up/down is enabled by defining OPERAND_AUTOREPEAT_EN.
module operand_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned OUT_W           = 16,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    btn_left_i,
  input  logic                    btn_right_i,
  input  logic                    btn_up_i,
  input  logic                    btn_down_i,
  input  logic                    btn_mid_i,
  input  logic                    clear_i,
  input  logic                    value_ready_i,
  output logic                    value_valid_o,
  output logic [OUT_W-1:0]        value_o,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [1:0]              cursor_o,
  output logic                    negative_o,
  output logic                    busy_o
);

  localparam int unsigned NumBtn = 5;
  localparam int unsigned CntW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BLeft  = 0;
  localparam int unsigned BRight = 1;
  localparam int unsigned BUp    = 2;
  localparam int unsigned BDown  = 3;
  localparam int unsigned BMid   = 4;

  typedef enum logic [1:0] {StEdit, StConvert, StSign, StHold} state_e;

  state_e state_q, state_d;

  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q;
  logic [NumBtn-1:0] lvl_q, lvl_d;
  logic [NumBtn-1:0] press_q, press_d;
  logic [CntW-1:0]   cnt_q [NumBtn];
  logic [CntW-1:0]   cnt_d [NumBtn];

  assign btn_raw = {btn_mid_i, btn_down_i, btn_up_i, btn_right_i, btn_left_i};

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    for (int i = 0; i < NumBtn; i++) begin
      lvl_d[i] = lvl_q[i];
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_d[i] = ~lvl_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    press_d = lvl_d & ~lvl_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      for (int i = 0; i < NumBtn; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic ev_up, ev_down;

`ifdef OPERAND_AUTOREPEAT_EN
  localparam int unsigned RepW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [RepW-1:0] rep_cnt_q;
  logic            rep_fire_q;
  logic            rep_hold;

  // Exactly one of up/down held, and only while editing.
  assign rep_hold = (state_q == StEdit) && (lvl_q[BUp] ^ lvl_q[BDown]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q  <= '0;
      rep_fire_q <= 1'b0;
    end else if (!rep_hold) begin
      rep_cnt_q  <= '0;
      rep_fire_q <= 1'b0;
    end else if (rep_cnt_q == RepW'(REPEAT_CYCLES - 1)) begin
      rep_cnt_q  <= '0;
      rep_fire_q <= 1'b1;
    end else begin
      rep_cnt_q  <= rep_cnt_q + RepW'(1);
      rep_fire_q <= 1'b0;
    end
  end

  assign ev_up   = press_q[BUp] | (rep_fire_q & lvl_q[BUp]);
  assign ev_down = press_q[BDown] | (rep_fire_q & lvl_q[BDown]);
`else
  logic [31:0] unused_repeat_cycles;
  assign unused_repeat_cycles = 32'(REPEAT_CYCLES);
  assign ev_up   = press_q[BUp];
  assign ev_down = press_q[BDown];
`endif

  logic [3:0]       digit_q [NUM_DIGITS];
  logic [3:0]       digit_d [NUM_DIGITS];
  logic [1:0]       cursor_q, cursor_d;
  logic [1:0]       idx_q, idx_d;
  logic             neg_q, neg_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] value_q, value_d;

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    cursor_d = cursor_q;
    idx_d    = idx_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    value_d  = value_q;
    unique case (state_q)
      StEdit: begin
        if (press_q[BMid]) begin
          acc_d   = '0;
          idx_d   = 2'(NUM_DIGITS - 1);
          state_d = StConvert;
        end else if (clear_i) begin
          for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = 4'd0;
          cursor_d = 2'd0;
          neg_d    = 1'b0;
        end else begin
          if (ev_up && ev_down) begin
            neg_d = ~neg_q;
          end else if (ev_up) begin
            digit_d[cursor_q] = (digit_q[cursor_q] == 4'd9) ? 4'd0 : digit_q[cursor_q] + 4'd1;
          end else if (ev_down) begin
            digit_d[cursor_q] = (digit_q[cursor_q] == 4'd0) ? 4'd9 : digit_q[cursor_q] - 4'd1;
          end
          if (press_q[BLeft] && !press_q[BRight]) begin
            cursor_d = (cursor_q == 2'(NUM_DIGITS - 1)) ? 2'd0 : cursor_q + 2'd1;
          end else if (press_q[BRight] && !press_q[BLeft]) begin
            cursor_d = (cursor_q == 2'd0) ? 2'(NUM_DIGITS - 1) : cursor_q - 2'd1;
          end
        end
      end
      StConvert: begin
        acc_d = acc_q * OUT_W'(10) + OUT_W'(digit_q[idx_q]);
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) state_d = StSign;
      end
      StSign: begin
        // Zero magnitude never becomes negative zero.
        value_d = (neg_q && acc_q != '0) ? -acc_q : acc_q;
        state_d = StHold;
      end
      StHold: begin
        if (value_ready_i) state_d = StEdit;
      end
      default: state_d = StEdit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StEdit;
      cursor_q <= 2'd0;
      idx_q    <= 2'd0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      value_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'd0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      idx_q    <= idx_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      value_q  <= value_d;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
    end
  end

  always_comb begin
    digits_o = '0;
    for (int i = 0; i < NUM_DIGITS; i++) digits_o[4*i +: 4] = digit_q[i];
  end

  assign value_valid_o = (state_q == StHold);
  assign busy_o        = (state_q != StEdit);
  assign value_o       = value_q;
  assign cursor_o      = cursor_q;
  assign negative_o    = neg_q;

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Input-side counterpart to the 7-segment result path: turns raw board buttons into a signed decimal operand for the ALU.
- Debounces the five buttons and edits a BCD digit buffer with a cursor.
- On mid press, converts the buffer to two's-complement binary and offers it through a valid/ready handshake.
- Exposes digits, cursor and sign so the display mux can show the operand while it is being entered.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a new button level (10 ms at 100 MHz).
- NUM_DIGITS, 4: decimal digits in the buffer, range 1..4.
- OUT_W, 16: output width. Requires 10^NUM_DIGITS-1 <= 2^(OUT_W-1)-1.
- REPEAT_CYCLES, 25000000: hold time per auto-repeat step (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- btn_left  in  1  raw button, move cursor toward MSD
- btn_right  in  1  raw button, move cursor toward LSD
- btn_up  in  1  raw button, increment digit at cursor
- btn_down  in  1  raw button, decrement digit at cursor
- btn_mid  in  1  raw button, commit operand
- clear  in  1  synchronous clear of buffer, sign and cursor
- value_ready  in  1  consumer accepts value
- value_valid  out  1  value is stable and offered
- value  out  OUT_W  signed operand
- digits  out  4*NUM_DIGITS  BCD digits; digit 0 is the LSD in bits [3:0]
- cursor  out  2  index of the selected digit
- negative  out  1  sign flag
- busy  out  1  high in CONVERT and HOLD

Behaviour:
- Reset (rst low, async): state EDIT; digits=0, cursor=0, negative=0, value=0, value_valid=0, busy=0; debounced levels=0; counters=0.
- Per-button debounce:
  - 2-FF synchronizer feeding a counter.
  - Counter clears whenever the synchronized sample equals the debounced level.
  - When it reaches DEBOUNCE_CYCLES-1 with a differing sample, the level flips.
  - A rising edge of the debounced level gives a 1-cycle press pulse.
  - Debounce runs in every state.
- EDIT state, press pulses only:
  - left: cursor = (cursor+1) mod NUM_DIGITS.
  - right: cursor = (cursor-1) mod NUM_DIGITS; both wrap around.
  - up: digit[cursor] = (d+1) mod 10, so 9 wraps to 0.
  - down: digit[cursor] = (d+9) mod 10, so 0 wraps to 9.
  - up and down in the same cycle: toggle negative, no digit change.
  - left and right in the same cycle: no effect.
  - mid has priority over all other pulses in the same cycle: accumulator=0, index=NUM_DIGITS-1, go to CONVERT.
  - clear: digits=0, cursor=0, negative=0. Ignored outside EDIT.
- CONVERT state:
  - One Horner step per cycle, MSD first: acc = acc*10 + digit[index]; index decrements.
  - Takes exactly NUM_DIGITS cycles, then one SIGN cycle: value = negative ? -acc : acc.
  - A magnitude of 0 always yields value 0 (negative zero is not produced).
  - After the SIGN cycle, go to HOLD.
- HOLD state:
  - value_valid=1; value and digits are frozen.
  - On value_valid && value_ready at a clock edge: value_valid=0 on the next cycle and the state returns to EDIT.
  - digits and sign are retained for further editing; value keeps its last result.
- Latency: with the mid pulse registered at edge t, value_valid is first high after edge t+NUM_DIGITS+2.
- Press pulses in CONVERT or HOLD are discarded, not queued.
- value_ready asserted outside HOLD has no effect.
- Reset asserted mid-CONVERT or mid-HOLD aborts immediately to the reset values.

Optional Feature:
- Macro OPERAND_AUTOREPEAT_EN.
- Defined: while the debounced up or down level stays high, one extra press pulse is generated every REPEAT_CYCLES cycles after the initial pulse, in EDIT only. The repeat counter resets on release or on leaving EDIT. Simultaneous up and down levels generate no repeats.
- Undefined: exactly one pulse per press; REPEAT_CYCLES is unused.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, NUM_DIGITS=4, OUT_W=16.
- Bounce: btn_up toggles every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one increment, digits=16'h0001.
- Entry: set digits to 1,2,3,4 (MSD..LSD) via cursor moves and up presses, then press mid -> value_valid rises NUM_DIGITS+2=6 cycles after the mid pulse, value=16'd1234; value_ready high 1 cycle -> value_valid low next cycle, state EDIT, digits still 16'h1234.
- Negative: digits 0,0,5,0, up and down pressed in the same debounced cycle, then mid -> negative=1, value=16'hFFCE (-50).
- Wrap: at cursor 0, press down on 0 -> digit 9; cursor 3, press left -> cursor 0; cursor 0, press right -> cursor 3.
- Backpressure and reset: in HOLD with value_ready=0 for 100 cycles, press up and mid -> value and digits unchanged, value_valid stays 1; pull rst low mid-CONVERT -> all outputs at reset values in the same cycle.
- With OPERAND_AUTOREPEAT_EN and REPEAT_CYCLES=10: hold up for 35 cycles after the debounce flip -> digit advances by 4.
